// File: rtl/cache_nway_pkg.sv
// -----------------------------------------------------------------------------
// Shared type packages for the N-way cache.
//   lc3b_types  : LC-3b pipeline word and byte-mask types.
//   cache_types : line geometry, cache FSM state encoding and PLRU sizing.
// No ports; imported by cache_nway_if, cache_nway and plru_tree.
// -----------------------------------------------------------------------------
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;
endpackage

package cache_types;
    localparam int LINE_W   = 128;
    localparam int OFFSET_W = 4;

    typedef logic [LINE_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } cache_state_e;

    // A binary PLRU tree over n ways has n-1 internal nodes.
    function automatic int plru_width(input int ways);
        return ways - 1;
    endfunction
endpackage

// File: rtl/cache_nway_if.sv
// -----------------------------------------------------------------------------
// cache_nway_if: CPU-side word port and memory-side line port of the cache.
//   mem_*  : LC-3b word requests (level read/write held until mem_resp).
//   pmem_* : 128-bit line fill / writeback towards physical memory.
// Modports:
//   slave  : the cache (serves mem_*, drives pmem_* requests).
//   master : the environment (CPU + physical memory).
// -----------------------------------------------------------------------------
interface cache_nway_if;
    import lc3b_types::*;
    import cache_types::*;

    lc3b_word      mem_address;
    logic          mem_read;
    logic          mem_write;
    lc3b_mem_wmask mem_byte_enable;
    lc3b_word      mem_wdata;
    lc3b_word      mem_rdata;
    logic          mem_resp;

    lc3b_word      pmem_address;
    logic          pmem_read;
    logic          pmem_write;
    line_t         pmem_wdata;
    line_t         pmem_rdata;
    logic          pmem_resp;

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        output mem_rdata, mem_resp,
        output pmem_address, pmem_read, pmem_write, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
        input  mem_rdata, mem_resp,
        input  pmem_address, pmem_read, pmem_write, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_nway_plru_tree.sv
// -----------------------------------------------------------------------------
// plru_tree: tree pseudo-LRU for one set of a WAYS-way cache.
// Ports:
//   plru        in  WAYS-1  current PLRU vector of the set
//   access_way  in  log2    way being accessed
//   victim_way  out log2    way the tree currently points at
//   plru_next   out WAYS-1  vector after an access to access_way
// Tree layout: level l decides bit l of the way number (LSB first). The node
// at level l for already-chosen low bits p sits at index (2^l - 1) + p. A node
// bit of 1 steers towards ways whose bit l is 1.
// -----------------------------------------------------------------------------
module plru_tree
    import cache_types::*;
#(
    parameter int WAYS = 4
) (
    input  logic [plru_width(WAYS)-1:0] plru,
    input  logic [$clog2(WAYS)-1:0]     access_way,
    output logic [$clog2(WAYS)-1:0]     victim_way,
    output logic [plru_width(WAYS)-1:0] plru_next
);
    localparam int LVL = $clog2(WAYS);

    typedef logic [LVL-1:0] way_t;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the loops can leave it unassigned and infer a latch.
        victim_way = '0;
        plru_next  = plru;
        for (int l = 0; l < LVL; l++) begin
            for (int p = 0; p < (1 << l); p++) begin
                if ((victim_way & way_t'((1 << l) - 1)) == way_t'(p))
                    victim_way[l] = plru[(1 << l) - 1 + p];
                // Point each node on the accessed path away from the access.
                if ((access_way & way_t'((1 << l) - 1)) == way_t'(p))
                    plru_next[(1 << l) - 1 + p] = ~access_way[l];
            end
        end
    end
endmodule

// File: rtl/cache_nway.sv
// -----------------------------------------------------------------------------
// cache_nway: N-way set-associative, write-back, write-allocate cache between
// the LC-3b memory port (16-bit words) and physical memory (128-bit lines).
// Parameters: WAYS (2..8, power of two), SETS (2..64, power of two).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : cache_nway_if.slave (mem_* word port, pmem_* line port)
//   hit_count, miss_count : 16-bit saturating counters, only present when
//                           CACHE_NWAY_PERF_EN is defined
// Hits answer combinationally in IDLE; misses go IDLE -> [WRITEBACK ->] FILL
// -> IDLE, after which the held request hits. Victim is the lowest invalid
// way, otherwise the tree-PLRU way.
// -----------------------------------------------------------------------------
module cache_nway
    import cache_types::*;
    import lc3b_types::*;
#(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic          clk,
    input  logic          reset,
    cache_nway_if.slave   bus
`ifdef CACHE_NWAY_PERF_EN
    ,
    output logic [15:0]   hit_count,
    output logic [15:0]   miss_count
`endif
);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 12 - IDX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = plru_width(WAYS);

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [WAY_W-1:0] way_t;

    line_t             data_arr  [SETS][WAYS];
    tag_t              tag_arr   [SETS][WAYS];
    logic [WAYS-1:0]   valid_arr [SETS];
    logic [WAYS-1:0]   dirty_arr [SETS];
    logic [PLRU_W-1:0] plru_arr  [SETS];

    cache_state_e state, state_next;

    // Miss context captured when leaving IDLE, so a dropped or changed
    // request cannot disturb an in-flight line transfer.
    idx_t miss_idx;
    tag_t miss_tag;
    way_t victim_q;

    idx_t     req_idx;
    tag_t     req_tag;
    logic [2:0] req_off;
    logic     req_any;
    logic     unused_addr_bit;

    assign req_idx         = bus.mem_address[OFFSET_W +: IDX_W];
    assign req_tag         = bus.mem_address[15 -: TAG_W];
    assign req_off         = bus.mem_address[3:1];
    assign req_any         = bus.mem_read | bus.mem_write;
    assign unused_addr_bit = bus.mem_address[0];

    // ---------------- hit detection and word select ----------------
    logic     hit_any;
    way_t     hit_way;
    lc3b_word hit_word;
    lc3b_word merged_word;
    logic     hit_resp;

    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_arr[req_idx][w] && (tag_arr[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = way_t'(w);
            end
        end
    end

    assign hit_word    = data_arr[req_idx][hit_way][{req_off, 4'b0000} +: 16];
    assign merged_word = {bus.mem_byte_enable[1] ? bus.mem_wdata[15:8] : hit_word[15:8],
                          bus.mem_byte_enable[0] ? bus.mem_wdata[7:0]  : hit_word[7:0]};
    assign hit_resp    = (state == IDLE) && req_any && hit_any;

    // ---------------- replacement ----------------
    way_t              plru_victim;
    logic [PLRU_W-1:0] plru_upd;
    way_t              vic_way;
    logic              vic_found;
    logic              vic_dirty;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .plru       (plru_arr[req_idx]),
        .access_way (hit_way),
        .victim_way (plru_victim),
        .plru_next  (plru_upd)
    );

    always_comb begin
        vic_way   = plru_victim;
        vic_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!vic_found && !valid_arr[req_idx][w]) begin
                vic_way   = way_t'(w);
                vic_found = 1'b1;
            end
        end
    end

    assign vic_dirty = valid_arr[req_idx][vic_way] && dirty_arr[req_idx][vic_way];

    // ---------------- control FSM ----------------
    logic     miss_start;
    logic     fill_done;
    logic     pmem_read_c;
    logic     pmem_write_c;
    lc3b_word pmem_address_c;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        pmem_read_c    = 1'b0;
        pmem_write_c   = 1'b0;
        pmem_address_c = '0;
        unique case (state)
            IDLE: begin
                if (req_any && !hit_any)
                    state_next = vic_dirty ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
                pmem_write_c   = 1'b1;
                pmem_address_c = {tag_arr[miss_idx][victim_q], miss_idx, {OFFSET_W{1'b0}}};
                if (bus.pmem_resp) state_next = FILL;
            end
            FILL: begin
                pmem_read_c    = 1'b1;
                pmem_address_c = {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
                if (bus.pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign miss_start = (state == IDLE) && (state_next != IDLE);
    assign fill_done  = (state == FILL) && bus.pmem_resp;

    assign bus.mem_resp     = hit_resp;
    assign bus.mem_rdata    = hit_word;
    assign bus.pmem_read    = pmem_read_c;
    assign bus.pmem_write   = pmem_write_c;
    assign bus.pmem_address = pmem_address_c;
    assign bus.pmem_wdata   = data_arr[miss_idx][victim_q];

    // ---------------- storage ----------------
    // NOTE: data, tag and miss-context storage has no reset; valid bits gate
    // every use of it, and leaving large arrays unreset keeps them as plain RAM.
    always_ff @(posedge clk) begin
        if (miss_start) begin
            miss_idx <= req_idx;
            miss_tag <= req_tag;
            victim_q <= vic_way;
        end
        if (hit_resp && bus.mem_write)
            data_arr[req_idx][hit_way][{req_off, 4'b0000} +: 16] <= merged_word;
        if (fill_done) begin
            data_arr[miss_idx][victim_q] <= bus.pmem_rdata;
            tag_arr[miss_idx][victim_q]  <= miss_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SETS; s++) begin
                valid_arr[s] <= '0;
                dirty_arr[s] <= '0;
                plru_arr[s]  <= '0;
            end
        end else begin
            if (hit_resp) begin
                plru_arr[req_idx] <= plru_upd;
                // A write marks the line dirty even with an all-zero mask.
                if (bus.mem_write) dirty_arr[req_idx][hit_way] <= 1'b1;
            end
            if (fill_done) begin
                valid_arr[miss_idx][victim_q] <= 1'b1;
                dirty_arr[miss_idx][victim_q] <= 1'b0;
            end
        end
    end

`ifdef CACHE_NWAY_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_resp && (hit_count != 16'hFFFF))     hit_count  <= hit_count + 16'd1;
            if (miss_start && (miss_count != 16'hFFFF))  miss_count <= miss_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cache_nway.sv
// -----------------------------------------------------------------------------
// tb_cache_nway: scoreboard bench for cache_nway (WAYS=4, SETS=8).
// Directed requests push their expected word and latency into resp_q; a
// monitor pops on every mem_resp. Expected line transfers go into pmem_q and
// the physical-memory model checks each one when it answers. Physical memory
// initially holds, at every word, that word's own byte address.
// Counter checks are compiled in when CACHE_NWAY_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_cache_nway;
    localparam int PMEM_LAT = 3;

    typedef struct {
        string       name;
        bit          is_read;
        logic [15:0] data;
        int          lat;
    } resp_t;

    typedef struct {
        bit           is_write;
        logic [15:0]  addr;
        logic [127:0] wdata;
    } pmem_t;

    logic clk = 1'b0;
    logic reset;
    cache_nway_if bus ();
`ifdef CACHE_NWAY_PERF_EN
    logic [15:0] hit_count, miss_count;
`endif

    cache_nway #(.WAYS(4), .SETS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef CACHE_NWAY_PERF_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           req_start = 0;
    int           pmem_cnt = 0;
    resp_t        resp_q[$];
    pmem_t        pmem_q[$];
    logic [127:0] mem [logic [15:0]];
    logic [127:0] wb_line;
    bit           seen;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_init(input logic [15:0] a);
        logic [127:0] l;
        for (int i = 0; i < 8; i++) l[i*16 +: 16] = {a[15:4], 4'(i * 2)};
        return l;
    endfunction

    task automatic exp_pmem(input bit is_write, input logic [15:0] addr, input logic [127:0] wdata);
        pmem_t t;
        t.is_write = is_write;
        t.addr     = addr;
        t.wdata    = wdata;
        pmem_q.push_back(t);
    endtask

    // Called just after a rising edge; returns just after the edge that
    // completed the request, with the request dropped.
    task automatic access(input string name, input bit rd, input bit wr,
                          input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd,
                          input logic [15:0] exp_data, input int exp_lat);
        resp_t e;
        bit    done;
        e.name    = name;
        e.is_read = rd && !wr;
        e.data    = exp_data;
        e.lat     = exp_lat;
        resp_q.push_back(e);
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        req_start = cyc;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = bus.mem_resp;
        end
        check({name, "_done"}, 128'(done), 1);
        @(posedge clk);
        #1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Response monitor.
    initial forever begin
        resp_t e;
        @(negedge clk);
        if (!reset && bus.mem_resp) begin
            check("resp_expected", 128'(resp_q.size() != 0), 1);
            if (resp_q.size() != 0) begin
                e = resp_q.pop_front();
                if (e.is_read) check({e.name, "_data"}, bus.mem_rdata, e.data);
                check({e.name, "_latency"}, 128'(cyc - req_start), 128'(e.lat));
            end
        end
    end

    // Physical memory: answers on the PMEM_LAT-th cycle of each request.
    initial forever begin
        pmem_t t;
        @(negedge clk);
        if (reset) begin
            bus.pmem_resp = 1'b0;
            pmem_cnt = 0;
        end else begin
            if (bus.pmem_resp) bus.pmem_resp = 1'b0;
            if (bus.pmem_read || bus.pmem_write) begin
                pmem_cnt++;
                if (pmem_cnt == PMEM_LAT) begin
                    pmem_cnt = 0;
                    check("pmem_exclusive", 128'(bus.pmem_read && bus.pmem_write), 0);
                    check("pmem_expected", 128'(pmem_q.size() != 0), 1);
                    if (pmem_q.size() != 0) begin
                        t = pmem_q.pop_front();
                        check("pmem_is_write", 128'(bus.pmem_write), 128'(t.is_write));
                        check("pmem_address", bus.pmem_address, t.addr);
                        if (t.is_write) begin
                            check("pmem_wdata", bus.pmem_wdata, t.wdata);
                            mem[t.addr] = bus.pmem_wdata;
                        end
                    end
                    if (bus.pmem_read)
                        bus.pmem_rdata = mem.exists(bus.pmem_address) ? mem[bus.pmem_address]
                                                                       : line_init(bus.pmem_address);
                    bus.pmem_resp = 1'b1;
                end
            end else begin
                pmem_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset               = 1'b1;
        bus.mem_address     = '0;
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = '0;
        bus.mem_wdata       = '0;
        bus.pmem_rdata      = '0;
        bus.pmem_resp       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mem_resp", bus.mem_resp, 0);
        check("rst_pmem_read", bus.pmem_read, 0);
        check("rst_pmem_write", bus.pmem_write, 0);
        check("rst_pmem_address", bus.pmem_address, 0);
        @(posedge clk);
        #1;

        // Cold read miss, then write-merge hit and read-back.
        exp_pmem(1'b0, 16'h1230, '0);
        access("rd_miss_1234", 1, 0, 16'h1234, 2'b00, 16'h0000, 16'h1234, 4);
        access("wr_hit_1234",  0, 1, 16'h1234, 2'b01, 16'hBEEF, 16'h0000, 0);
        access("rd_merge_1234", 1, 0, 16'h1234, 2'b00, 16'h0000, 16'h12EF, 0);

        // Fill remaining ways of index 3 (ways 1, 2, 3).
        exp_pmem(1'b0, 16'h0030, '0);
        access("fill_w1", 1, 0, 16'h0034, 2'b00, 16'h0000, 16'h0034, 4);
        exp_pmem(1'b0, 16'h00B0, '0);
        access("fill_w2", 1, 0, 16'h00B4, 2'b00, 16'h0000, 16'h00B4, 4);
        exp_pmem(1'b0, 16'h0130, '0);
        access("fill_w3", 1, 0, 16'h0134, 2'b00, 16'h0000, 16'h0134, 4);

        // Fifth tag: PLRU victim is dirty way 0 -> writeback then fill.
        wb_line = line_init(16'h1230);
        wb_line[47:32] = 16'h12EF;
        exp_pmem(1'b1, 16'h1230, wb_line);
        exp_pmem(1'b0, 16'h01B0, '0);
        access("evict_dirty", 1, 0, 16'h01B4, 2'b00, 16'h0000, 16'h01B4, 7);

        // Hit ways 0, 1, 2; the next miss must replace way 3 (tag 2).
        access("hit_w0", 1, 0, 16'h01B4, 2'b00, 16'h0000, 16'h01B4, 0);
        access("hit_w1", 1, 0, 16'h003A, 2'b00, 16'h0000, 16'h003A, 0);
        access("hit_w2", 1, 0, 16'h00B4, 2'b00, 16'h0000, 16'h00B4, 0);
        exp_pmem(1'b0, 16'h0230, '0);
        access("evict_w3", 1, 0, 16'h0234, 2'b00, 16'h0000, 16'h0234, 4);
        exp_pmem(1'b0, 16'h0130, '0);
        access("refetch_tag2", 1, 0, 16'h0134, 2'b00, 16'h0000, 16'h0134, 4);
        access("w2_retained", 1, 0, 16'h00B4, 2'b00, 16'h0000, 16'h00B4, 0);

        // Write-allocate miss, high-byte merge, read+write treated as write.
        exp_pmem(1'b0, 16'h4440, '0);
        access("wr_miss_4444", 0, 1, 16'h4444, 2'b11, 16'h5678, 16'h0000, 4);
        access("rd_4444", 1, 0, 16'h4444, 2'b00, 16'h0000, 16'h5678, 0);
        access("wr_hi_4446", 0, 1, 16'h4446, 2'b10, 16'hCD99, 16'h0000, 0);
        access("rd_4446", 1, 0, 16'h4446, 2'b00, 16'h0000, 16'hCD46, 0);
        access("rdwr_4448", 1, 1, 16'h4448, 2'b11, 16'h1111, 16'h0000, 0);
        access("rd_4448", 1, 0, 16'h4448, 2'b00, 16'h0000, 16'h1111, 0);

        // Reset during FILL aborts the transfer.
        bus.mem_address = 16'h0634;
        bus.mem_read    = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.pmem_read;
        end
        check("abort_fill_started", 128'(seen), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pmem_read", bus.pmem_read, 0);
        check("abort_mem_resp", bus.mem_resp, 0);
        bus.mem_read = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_pmem(1'b0, 16'h0630, '0);
        access("rd_after_abort", 1, 0, 16'h0634, 2'b00, 16'h0000, 16'h0634, 4);
        exp_pmem(1'b0, 16'h00B0, '0);
        access("rd_after_reset", 1, 0, 16'h00B4, 2'b00, 16'h0000, 16'h00B4, 4);

`ifdef CACHE_NWAY_PERF_EN
        do_reset();
        exp_pmem(1'b0, 16'h0030, '0);
        access("perf_miss_a", 1, 0, 16'h0034, 2'b00, 16'h0000, 16'h0034, 4);
        exp_pmem(1'b0, 16'h00B0, '0);
        access("perf_miss_b", 1, 0, 16'h00B4, 2'b00, 16'h0000, 16'h00B4, 4);
        access("perf_hit_a", 1, 0, 16'h0034, 2'b00, 16'h0000, 16'h0034, 0);
        @(negedge clk);
        check("perf_hit_count", hit_count, 3);
        check("perf_miss_count", miss_count, 2);
        @(posedge clk);
        #1;
        do_reset();
        @(negedge clk);
        check("perf_hit_count_rst", hit_count, 0);
        check("perf_miss_count_rst", miss_count, 0);
`else
        do_reset();
`endif

        repeat (2) @(negedge clk);
        check("resp_queue_drained", 128'(resp_q.size()), 0);
        check("pmem_queue_drained", 128'(pmem_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cache_nway.md
Name: cache_nway

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache.
- Integrates the datapath and control FSM, with tree pseudo-LRU replacement.
- Sits between the LC-3b pipeline memory port (16-bit words) and physical memory (128-bit lines).
- Successor to the fixed 2-way cache; generalises way and set count and adds invalid-way-first victim choice.

Parameters:
- WAYS, 4, associativity; power of two, 2..8.
- SETS, 8, sets per way; power of two, 2..64.
- Derived, not overridable: IDX_W = log2(SETS), TAG_W = 12 - IDX_W. Line is 16 bytes: offset bits [3:0].

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- mem_address  in  16  byte address (lc3b_word).
- mem_read  in  1  read request, level, held until mem_resp.
- mem_write  in  1  write request, level, held until mem_resp.
- mem_byte_enable  in  2  byte mask (lc3b_mem_wmask).
- mem_wdata  in  16  write word.
- mem_rdata  out  16  read word, valid while mem_resp=1.
- mem_resp  out  1  request complete.
- pmem_address  out  16  line address, bits [3:0]=0.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_wdata  out  128  victim line.
- pmem_rdata  in  128  fill line.
- pmem_resp  in  1  pmem transfer complete.

Behaviour:
- Address split: word offset [3:1], index [3+IDX_W:4], tag [15:4+IDX_W].
- Arrays per set/way: data[128], tag[TAG_W], valid, dirty. One PLRU vector of WAYS-1 bits per set.
- FSM states: IDLE, WRITEBACK, FILL.
- IDLE, hit (valid & tag match, at most one way):
  - mem_resp=1 combinationally in the same cycle.
  - Read: mem_rdata = selected word.
  - Write: merge mem_wdata bytes per mem_byte_enable into the line at the clock edge; set dirty=1 (even when the mask is 0).
  - PLRU updated at the edge to point away from the hit way.
- IDLE, miss with a request pending: choose victim = lowest-numbered invalid way, else the PLRU way. Victim is registered on leaving IDLE.
  - Victim valid & dirty -> WRITEBACK; otherwise -> FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={victim tag, index, 4'b0}, pmem_wdata=victim line.
  - Held until pmem_resp, then -> FILL.
- FILL:
  - pmem_read=1, pmem_address={tag, index, 4'b0}.
  - On pmem_resp: data=pmem_rdata, tag=tag, valid=1, dirty=0; -> IDLE.
  - The request then hits on the following cycle. Miss latency = pmem cycles + 1.
- mem_resp=0 outside IDLE. pmem_read and pmem_write are never asserted together.
- mem_read and mem_write both high: treated as a write.
- Request dropped mid-miss: the miss completes normally; no response is generated.
- Reset:
  - Clears all valid, dirty and PLRU bits; FSM -> IDLE.
  - Data and tag arrays are not cleared.
  - After reset: mem_resp=0, pmem_read=0, pmem_write=0, pmem_address=0.
  - Reset mid-miss aborts the transfer at the edge; the partial line is discarded.
- Outputs are registered or decoded from state, except mem_resp and mem_rdata on a hit.

Optional Feature:
- Macro: CACHE_NWAY_PERF_EN.
- Defined: adds 16-bit saturating outputs hit_count and miss_count.
  - hit_count increments on each hit mem_resp.
  - miss_count increments on each IDLE->WRITEBACK/FILL transition.
  - Both clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cache_types: line width 128, offset bits 4, the FSM state enum, and a function computing PLRU vector width.
- Reuse lc3b_types for lc3b_word and lc3b_mem_wmask.
- One sub-module, plru_tree #(WAYS), containing:
  - Combinational victim-way output from the PLRU vector.
  - Next-vector computation on access to a given way.

Test Plan:
- Reset, then read 0x1234 -> miss: pmem_read with pmem_address=0x1230, no pmem_write; after pmem_resp, mem_resp next cycle with the word at offset 2 of pmem_rdata.
- Write 0xBEEF to 0x1234, mask 2'b01 (line already cached) -> same-cycle mem_resp, low byte 0xEF updated, dirty=1; a read of 0x1234 returns {old high byte, 0xEF}.
- WAYS=4, SETS=8: fill 4 tags in index 3, then a 5th tag -> victim is the PLRU way; if that way is dirty, pmem_write precedes pmem_read with address {old tag, 3, 0}.
- Hit ways 0, 1, 2 in order, then miss -> victim is way 3 (PLRU); fill order on an empty set is 0, 1, 2, 3.
- Reset asserted during FILL, before pmem_resp -> next cycle pmem_read=0; the same address misses again.
- With CACHE_NWAY_PERF_EN defined: 3 hits and 2 misses -> hit_count=3, miss_count=2; both return to 0 after reset.
